hyperbus_wb_burst: RTL and testbench
====================================

Name: hyperbus_wb_burst

Overview:
Wishbone B4 classic/registered-feedback slave bridging to the single-clock HyperBus FIFO request interface. Successor to the single-beat bridge, with these additions:
- parametrised data width
- real read-data wait (ack only on rx_valid_i)
- incrementing and wrapping bursts (CTI/BTE) with one-beat read prefetch
- programmable response timeout reported on wb_err_o
Sits between the SoC Wishbone interconnect and the hyperbus FIFO, all on wb_clk.

Parameters:
WB_DATA_WIDTH, 32, Wishbone/FIFO word width; multiple of 8, power of two.
WB_ADDR_WIDTH, 32, byte address width.
TIMEOUT, 1024, cycles to wait for tx_done_i/rx_valid_i before error; 0 disables timeout.
Derived (localparam): SEL_W = WB_DATA_WIDTH/8, BPW_LOG2 = log2(SEL_W).

Ports:
wb_clk  in  1  single clock for the whole block.
wb_rst  in  1  reset, synchronous, active-high.
wb_adr_i  in  WB_ADDR_WIDTH  byte address.
wb_dat_i  in  WB_DATA_WIDTH  write data.
wb_we_i  in  1  write enable.
wb_sel_i  in  SEL_W  byte selects.
wb_cyc_i, wb_stb_i  in  1  cycle/strobe.
wb_cti_i  in  3  000 classic, 010 incrementing, 111 end-of-burst.
wb_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
wb_dat_o  out  WB_DATA_WIDTH  read data, registered.
wb_ack_o  out  1  one-cycle ack.
wb_err_o  out  1  one-cycle error (timeout).
wb_rty_o  out  1  tied 0.
req_adr_o  out  WB_ADDR_WIDTH  word-aligned request address (low BPW_LOG2 bits 0).
req_dat_o  out  WB_DATA_WIDTH  write data.
req_mask_o  out  SEL_W  active-high byte mask = ~sel.
req_rrq_o, req_wrq_o  out  1  one-cycle request pulses.
tx_done_i  in  1  write accepted.
rx_valid_i  in  1  read data valid pulse.
rx_dat_i  in  WB_DATA_WIDTH  read data, valid with rx_valid_i.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0; prefetch buffer invalid. wb_rst mid-operation abandons everything. Late tx_done_i/rx_valid_i arriving in IDLE are ignored.
- Request outputs: req_adr/dat/mask are registered and held stable from the request pulse until the response arrives.
- States:
  - IDLE: cyc&stb&~ack&~err → latch request, pulse req_wrq_o (we=1 → WR_WAIT) or req_rrq_o (we=0 → RD_WAIT).
  - WR_WAIT: tx_done_i → ack next cycle → IDLE.
  - RD_WAIT: rx_valid_i → wb_dat_o<=rx_dat_i, ack next cycle.
    - If latched cti=010: compute next address, pulse req_rrq_o → PF_WAIT.
    - Otherwise → IDLE.
  - PF_WAIT: rx_valid_i → capture buffer → PF_HOLD. If the master presents a non-matching beat while waiting → DRAIN.
  - PF_HOLD: each cycle check cyc&stb&~we&adr==predicted.
    - Match → ack with buffer data. If cti=010, prefetch again (→ PF_WAIT); if cti=111, → IDLE.
    - Mismatch, cyc low, or we=1 → discard buffer → IDLE; the pending request is re-evaluated next cycle.
  - DRAIN: wait for the outstanding rx_valid_i, discard data → IDLE.
- Next address: A + SEL_W.
  - Linear: full-width add.
  - Wrap N (4/8/16): only bits [log2(N)+BPW_LOG2-1 : BPW_LOG2] increment modulo N; upper bits unchanged.
- Ack rules:
  - Never ack two consecutive cycles for non-burst; ack is never asserted without cyc&stb.
  - ack and err are mutually exclusive.
- Latency: single read with rx_valid_i at cycle n → ack at n+1. Prefetched burst beat → ack 1 cycle after the master presents the matching address, if data is already in the buffer.
- Timeout:
  - Counter resets on entry to every wait state.
  - WR_WAIT/RD_WAIT reaching TIMEOUT → wb_err_o pulse → IDLE.
  - PF_WAIT/DRAIN reaching TIMEOUT → IDLE silently; a master beat then issues a fresh request.
- Simultaneous events:
  - rx_valid_i and a mismatching master beat in the same cycle in PF_WAIT → data discarded → IDLE.
  - cyc dropping in RD_WAIT/WR_WAIT → continue waiting for the response, suppress ack, → IDLE.

Decomposition:
- Shared package hyperbus_pkg: CTI/BTE encodings, state encodings (one-hot, 6 states), and the wrap-increment function.
- One sub-module, hyperbus_burst_addr: combinational next-address generator (address, bte → next). Everything else stays in the top module.

Test Plan:
- Single write, adr 0x100, sel 0011, tx_done_i 5 cycles after wrq → req_mask_o=1100, req_adr_o=0x100, one ack 1 cycle after tx_done_i.
- Single read, adr 0x203 → req_adr_o=0x200, rx_dat_i=0xDEADBEEF 7 cycles later → wb_dat_o=0xDEADBEEF with ack next cycle.
- Wrap4 read burst from 0x1C (cti 010 ×3, then 111) → requests 0x1C, 0x10, 0x14, 0x18; four acks in order; no fifth rrq.
- Linear burst aborted after beat 2 (cyc low while prefetch outstanding) → DRAIN absorbs late rx_valid_i; no ack; next single write proceeds normally.
- TIMEOUT=16, no tx_done_i → wb_err_o pulses exactly at cycle 17 after wrq; no ack; IDLE afterwards.
- wb_rst asserted in RD_WAIT, then rx_valid_i → no ack; all outputs 0; next read serviced.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Wishbone-to-HyperBus burst bridge:
// CTI/BTE encodings, one-hot FSM states and the wrap-burst index step.
package hyperbus_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WR_WAIT = 6'b000010,
    ST_RD_WAIT = 6'b000100,
    ST_PF_WAIT = 6'b001000,
    ST_PF_HOLD = 6'b010000,
    ST_DRAIN   = 6'b100000
  } state_e;

  // Step the low four bits of a word index; only the bits covered by the
  // wrap length count up (modulo N), the rest keep their value.
  function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input logic [1:0] bte);
    logic [3:0] mask;
    logic [3:0] inc;
    case (bte)
      BTE_WRAP4:  mask = 4'b0011;
      BTE_WRAP8:  mask = 4'b0111;
      BTE_WRAP16: mask = 4'b1111;
      default:    mask = 4'b1111;
    endcase
    inc = idx + 4'd1;
    return (idx & ~mask) | (inc & mask);
  endfunction

endpackage

// File: rtl/hyperbus_burst_addr.sv
// Combinational next-beat address for incrementing and wrapping bursts.
// The input is a word-aligned byte address; the output is word-aligned too.
module hyperbus_burst_addr
  import hyperbus_pkg::*;
#(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
) (
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [1:0]               bte_i,
  output logic [WB_ADDR_WIDTH-1:0] nxt_o
);

  localparam int SEL_W    = WB_DATA_WIDTH / 8;
  localparam int BPW_LOG2 = $clog2(SEL_W);
  localparam logic [WB_ADDR_WIDTH-1:0] LOW_MASK =
    WB_ADDR_WIDTH'((64'd1 << BPW_LOG2) - 64'd1);

  logic [WB_ADDR_WIDTH-1:0] lin_s;
  logic [WB_ADDR_WIDTH-1:0] wrap_s;
  logic [WB_ADDR_WIDTH-1:0] nxt_s;

  // Linear bursts carry through the full width; wrap bursts only touch the index bits.
  always_comb begin
    lin_s  = adr_i + WB_ADDR_WIDTH'(SEL_W);
    wrap_s = adr_i;
    wrap_s[BPW_LOG2 +: 4] = wrap_inc(adr_i[BPW_LOG2 +: 4], bte_i);
    if (bte_i == BTE_LINEAR) begin
      nxt_s = lin_s;
    end else begin
      nxt_s = wrap_s;
    end
    nxt_o = nxt_s & ~LOW_MASK;
  end

endmodule

// File: rtl/hyperbus_wb_burst.sv
// Wishbone B4 classic/registered-feedback slave in front of the HyperBus
// FIFO request interface. Handles single accesses, CTI/BTE bursts with a
// one-beat read prefetch, and a response timeout reported on wb_err_o.
module hyperbus_wb_burst
  import hyperbus_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int TIMEOUT       = 1024
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [WB_ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                       wb_we_i,
  input  logic [WB_DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic [2:0]                 wb_cti_i,
  input  logic [1:0]                 wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic                       wb_rty_o,
  output logic [WB_ADDR_WIDTH-1:0]   req_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   req_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0] req_mask_o,
  output logic                       req_rrq_o,
  output logic                       req_wrq_o,
  input  logic                       tx_done_i,
  input  logic                       rx_valid_i,
  input  logic [WB_DATA_WIDTH-1:0]   rx_dat_i
);

  localparam int SEL_W    = WB_DATA_WIDTH / 8;
  localparam int BPW_LOG2 = $clog2(SEL_W);
  localparam int TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
  localparam logic [WB_ADDR_WIDTH-1:0] LOW_MASK =
    WB_ADDR_WIDTH'((64'd1 << BPW_LOG2) - 64'd1);

  state_e                   state_q,    state_d;
  logic [WB_ADDR_WIDTH-1:0] req_adr_q,  req_adr_d;
  logic [WB_DATA_WIDTH-1:0] req_dat_q,  req_dat_d;
  logic [SEL_W-1:0]         req_mask_q, req_mask_d;
  logic                     rrq_q,      rrq_d;
  logic                     wrq_q,      wrq_d;
  logic                     ack_q,      ack_d;
  logic                     err_q,      err_d;
  logic [WB_DATA_WIDTH-1:0] dat_q,      dat_d;
  logic [WB_DATA_WIDTH-1:0] buf_q,      buf_d;
  logic [TMO_W-1:0]         cnt_q,      cnt_d;
  logic [2:0]               cti_q,      cti_d;
  logic [1:0]               bte_q,      bte_d;
  logic                     abort_q,    abort_d;

  logic [WB_ADDR_WIDTH-1:0] nxt_adr_s;
  logic [WB_ADDR_WIDTH-1:0] adr_word_s;
  logic                     beat_s;
  logic                     aborted_s;
  logic                     tmo_hit_s;
  logic                     pf_match_s;
  logic                     pf_miss_s;

  hyperbus_burst_addr #(
    .WB_ADDR_WIDTH (WB_ADDR_WIDTH),
    .WB_DATA_WIDTH (WB_DATA_WIDTH)
  ) u_burst_addr (
    .adr_i (req_adr_q),
    .bte_i (bte_q),
    .nxt_o (nxt_adr_s)
  );

  // Decode the master's current beat against the outstanding/predicted address.
  always_comb begin
    beat_s     = wb_cyc_i & wb_stb_i;
    adr_word_s = wb_adr_i & ~LOW_MASK;
    aborted_s  = abort_q | ~wb_cyc_i;
    tmo_hit_s  = TMO_EN && (cnt_q == TMO_MAX);
    pf_match_s = beat_s & ~wb_we_i & (adr_word_s == req_adr_q);
    // The beat still on the bus during its own ack cycle is not a new beat.
    pf_miss_s  = ~ack_q & (~wb_cyc_i | (wb_stb_i & (wb_we_i | (adr_word_s != req_adr_q))));
  end

  // Next-state and next-output computation for the bridge FSM.
  always_comb begin
    state_d    = state_q;
    req_adr_d  = req_adr_q;
    req_dat_d  = req_dat_q;
    req_mask_d = req_mask_q;
    rrq_d      = 1'b0;
    wrq_d      = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = dat_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    cti_d      = cti_q;
    bte_d      = bte_q;
    abort_d    = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_s && !ack_q && !err_q) begin
          req_adr_d  = adr_word_s;
          req_dat_d  = wb_dat_i;
          req_mask_d = ~wb_sel_i;
          cti_d      = wb_cti_i;
          bte_d      = wb_bte_i;
          cnt_d      = '0;
          abort_d    = 1'b0;
          if (wb_we_i) begin
            wrq_d   = 1'b1;
            state_d = ST_WR_WAIT;
          end else begin
            rrq_d   = 1'b1;
            state_d = ST_RD_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        abort_d = aborted_s;
        if (tx_done_i) begin
          ack_d   = ~aborted_s & wb_stb_i;
          state_d = ST_IDLE;
        end else if (tmo_hit_s) begin
          err_d   = ~aborted_s & wb_stb_i;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_RD_WAIT: begin
        abort_d = aborted_s;
        if (rx_valid_i) begin
          dat_d = rx_dat_i;
          ack_d = ~aborted_s & wb_stb_i;
          if ((cti_q == CTI_INCR) && !aborted_s) begin
            req_adr_d = nxt_adr_s;
            rrq_d     = 1'b1;
            cnt_d     = '0;
            state_d   = ST_PF_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          err_d   = ~aborted_s & wb_stb_i;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_PF_WAIT: begin
        if (rx_valid_i) begin
          if (pf_miss_s) begin
            state_d = ST_IDLE;
          end else begin
            buf_d   = rx_dat_i;
            state_d = ST_PF_HOLD;
          end
        end else if (pf_miss_s) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (tmo_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_PF_HOLD: begin
        if (ack_q || (wb_cyc_i && !wb_stb_i)) begin
          state_d = ST_PF_HOLD;
        end else if (pf_match_s) begin
          ack_d = 1'b1;
          dat_d = buf_q;
          if (wb_cti_i == CTI_INCR) begin
            req_adr_d = nxt_adr_s;
            rrq_d     = 1'b1;
            cnt_d     = '0;
            state_d   = ST_PF_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (rx_valid_i || tmo_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; wb_rst abandons any transfer in flight.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= ST_IDLE;
      req_adr_q  <= '0;
      req_dat_q  <= '0;
      req_mask_q <= '0;
      rrq_q      <= 1'b0;
      wrq_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      buf_q      <= '0;
      cnt_q      <= '0;
      cti_q      <= CTI_CLASSIC;
      bte_q      <= BTE_LINEAR;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_adr_q  <= req_adr_d;
      req_dat_q  <= req_dat_d;
      req_mask_q <= req_mask_d;
      rrq_q      <= rrq_d;
      wrq_q      <= wrq_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      cti_q      <= cti_d;
      bte_q      <= bte_d;
      abort_q    <= abort_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign req_adr_o  = req_adr_q;
  assign req_dat_o  = req_dat_q;
  assign req_mask_o = req_mask_q;
  assign req_rrq_o  = rrq_q;
  assign req_wrq_o  = wrq_q;

endmodule

// File: tb/tb_hyperbus_wb_burst.sv
// Directed bench for hyperbus_wb_burst. A transaction-level model turns
// each scenario into expected per-cycle events (request pulses with their
// addresses, acks with read data, errors); a monitor compares every cycle.
module tb_hyperbus_wb_burst;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [31:0] req_adr_o;
  logic [31:0] req_dat_o;
  logic [3:0]  req_mask_o;
  logic        req_rrq_o;
  logic        req_wrq_o;
  logic        tx_done_i;
  logic        rx_valid_i;
  logic [31:0] rx_dat_i;

  hyperbus_wb_burst #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .req_adr_o(req_adr_o), .req_dat_o(req_dat_o),
    .req_mask_o(req_mask_o), .req_rrq_o(req_rrq_o), .req_wrq_o(req_wrq_o),
    .tx_done_i(tx_done_i), .rx_valid_i(rx_valid_i), .rx_dat_i(rx_dat_i));

  always #5 wb_clk = ~wb_clk;

  int cnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_rrq = 0;
  int n_ack = 0;
  bit mon_en = 1'b0;

  bit          exp_ack[int];
  bit          exp_err[int];
  logic [31:0] exp_dat[int];
  logic [31:0] exp_rrq[int];
  logic [31:0] exp_wrq[int];

  int          bd[16];
  int          bg[16];
  int          s_p[16];
  int          s_a[16];
  int          s_r[16];
  int          s_rq[16];
  logic [31:0] s_ad[16];

  always @(posedge wb_clk) cnt <= cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cnt);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // Spec-level address sequence: linear adds a word, wrap N stays in its N-word block.
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] span;
    case (bte)
      2'b01:   span = 32'd16;
      2'b10:   span = 32'd32;
      2'b11:   span = 32'd64;
      default: span = 32'd0;
    endcase
    if (span == 32'd0) return a + 32'd4;
    return (a - (a % span)) + (((a % span) + 32'd4) % span);
  endfunction

  // Per-cycle comparison of the DUT against the expected event schedule.
  always @(negedge wb_clk) begin
    if (mon_en) begin
      chk("ack", 64'(wb_ack_o), exp_ack.exists(cnt) ? 64'd1 : 64'd0);
      chk("err", 64'(wb_err_o), exp_err.exists(cnt) ? 64'd1 : 64'd0);
      chk("rrq", 64'(req_rrq_o), exp_rrq.exists(cnt) ? 64'd1 : 64'd0);
      chk("wrq", 64'(req_wrq_o), exp_wrq.exists(cnt) ? 64'd1 : 64'd0);
      chk("rty", 64'(wb_rty_o), 64'd0);
      if (wb_ack_o && exp_dat.exists(cnt)) chk("rdata", 64'(wb_dat_o), 64'(exp_dat[cnt]));
      if (req_rrq_o && exp_rrq.exists(cnt)) chk("rrq_adr", 64'(req_adr_o), 64'(exp_rrq[cnt]));
      if (req_wrq_o && exp_wrq.exists(cnt)) chk("wrq_adr", 64'(req_adr_o), 64'(exp_wrq[cnt]));
      n_rrq <= n_rrq + (req_rrq_o ? 1 : 0);
      n_ack <= n_ack + (wb_ack_o ? 1 : 0);
    end
  end

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; tx_done_i = 1'b0; rx_valid_i = 1'b0;
  endtask

  // Build the schedule of one transfer (single or burst) from the latency
  // rules, then drive it cycle by cycle. bd[i]: response delay after the
  // request pulse; bg[i]: idle cycles the master inserts before beat i.
  task automatic run_burst(input logic we, input logic [31:0] start, input logic [1:0] bte,
                           input int n, input bit abort, input logic [31:0] dbase,
                           input logic [3:0] sel);
    int t0;
    int last;
    t0 = cnt;
    s_ad[0] = start & 32'hFFFF_FFFC;
    s_p[0]  = t0;
    s_rq[0] = t0 + 1;
    s_r[0]  = s_rq[0] + bd[0];
    s_a[0]  = s_r[0] + 1;
    for (int i = 1; i < n; i++) begin
      s_ad[i] = model_next(s_ad[i-1], bte);
      s_rq[i] = s_a[i-1];
      s_p[i]  = s_a[i-1] + 1 + bg[i];
      s_r[i]  = s_rq[i] + bd[i];
      s_a[i]  = ((s_p[i] > s_r[i] + 1) ? s_p[i] : s_r[i] + 1) + 1;
    end
    for (int i = 0; i < n; i++) begin
      if (we) exp_wrq[s_rq[i]] = s_ad[i];
      else    exp_rrq[s_rq[i]] = s_ad[i];
      exp_ack[s_a[i]] = 1'b1;
      if (!we) exp_dat[s_a[i]] = dbase + 32'(i);
    end
    if (abort) exp_rrq[s_a[n-1]] = model_next(s_ad[n-1], bte);
    last = s_a[n-1];
    for (int c = t0; c <= last; c++) begin
      wb_cyc_i = 1'b1; wb_stb_i = 1'b0; rx_valid_i = 1'b0; tx_done_i = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (c >= s_p[i] && c <= s_a[i]) begin
          wb_stb_i = 1'b1;
          wb_adr_i = (i == 0) ? start : s_ad[i];
          wb_we_i  = we;
          wb_sel_i = sel;
          wb_dat_i = dbase + 32'(i);
          wb_bte_i = bte;
          if (n == 1 && !abort)        wb_cti_i = 3'b000;
          else if (i == n-1 && !abort) wb_cti_i = 3'b111;
          else                         wb_cti_i = 3'b010;
        end
        if (c == s_r[i]) begin
          if (we) tx_done_i = 1'b1;
          else begin
            rx_valid_i = 1'b1;
            rx_dat_i   = dbase + 32'(i);
          end
        end
      end
      step(1);
    end
    idle_bus();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"},  64'(wb_ack_o),   64'd0);
    chk({nm, "_err"},  64'(wb_err_o),   64'd0);
    chk({nm, "_dat"},  64'(wb_dat_o),   64'd0);
    chk({nm, "_radr"}, 64'(req_adr_o),  64'd0);
    chk({nm, "_rdat"}, 64'(req_dat_o),  64'd0);
    chk({nm, "_mask"}, 64'(req_mask_o), 64'd0);
    chk({nm, "_rrq"},  64'(req_rrq_o),  64'd0);
    chk({nm, "_wrq"},  64'(req_wrq_o),  64'd0);
  endtask

  initial begin
    int t0;
    int base_rrq;
    int base_ack;
    wb_rst = 1'b1; wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'd0;
    wb_cti_i = 3'd0; wb_bte_i = 2'd0; rx_dat_i = 32'd0;
    idle_bus();
    step(3);
    chk_all_zero("reset");
    wb_rst = 1'b0;
    step(1);
    mon_en = 1'b1;

    // Pin the model's address arithmetic to hand-computed values.
    chk("model_wrap4",  64'(model_next(32'h1C, 2'b01)), 64'h10);
    chk("model_wrap8",  64'(model_next(32'h3C, 2'b10)), 64'h20);
    chk("model_wrap16", 64'(model_next(32'h7C, 2'b11)), 64'h40);
    chk("model_linear", 64'(model_next(32'hFC, 2'b00)), 64'h100);

    // Single write: tx_done 5 cycles after the request pulse.
    bd[0] = 5;
    run_burst(1'b1, 32'h100, 2'b00, 1, 1'b0, 32'hA5A5_1234, 4'b0011);
    chk("wr_mask", 64'(req_mask_o), 64'hC);
    chk("wr_adr",  64'(req_adr_o),  64'h100);
    chk("wr_dat",  64'(req_dat_o),  64'hA5A5_1234);
    step(2);

    // Single read at an unaligned address, data 7 cycles after the request.
    bd[0] = 7;
    run_burst(1'b0, 32'h203, 2'b00, 1, 1'b0, 32'hDEAD_BEEF, 4'hF);
    chk("rd_dat", 64'(wb_dat_o),  64'hDEAD_BEEF);
    chk("rd_adr", 64'(req_adr_o), 64'h200);
    step(2);

    // Wrap4 read burst from 0x1C; last beat shows buffered data with a master gap.
    base_rrq = n_rrq; base_ack = n_ack;
    bd[0] = 2; bd[1] = 2; bd[2] = 1; bd[3] = 1;
    bg[0] = 0; bg[1] = 0; bg[2] = 0; bg[3] = 2;
    run_burst(1'b0, 32'h1C, 2'b01, 4, 1'b0, 32'h1000_0000, 4'hF);
    step(3);
    chk("wrap4_rrq_count", 64'(n_rrq - base_rrq), 64'd4);
    chk("wrap4_ack_count", 64'(n_ack - base_ack), 64'd4);
    chk("wrap4_last_dat",  64'(wb_dat_o), 64'h1000_0003);

    // Linear 3-beat burst crossing 0x100.
    bd[0] = 1; bd[1] = 1; bd[2] = 1;
    bg[0] = 0; bg[1] = 1; bg[2] = 0;
    run_burst(1'b0, 32'hFC, 2'b00, 3, 1'b0, 32'h2000_0000, 4'hF);
    chk("lin_last_adr", 64'(req_adr_o), 64'h104);
    step(2);

    // Linear burst abandoned after beat 2 while the prefetch is outstanding.
    base_ack = n_ack;
    bd[0] = 2; bd[1] = 3; bg[0] = 0; bg[1] = 0;
    run_burst(1'b0, 32'h40, 2'b00, 2, 1'b1, 32'h3000_0000, 4'hF);
    chk("abort_pf_adr", 64'(req_adr_o), 64'h48);
    step(2);
    rx_valid_i = 1'b1; rx_dat_i = 32'hBAD0_BAD0;
    step(1);
    rx_valid_i = 1'b0;
    step(2);
    chk("abort_ack_count", 64'(n_ack - base_ack), 64'd2);
    bd[0] = 2;
    run_burst(1'b1, 32'h80, 2'b00, 1, 1'b0, 32'h0BAD_F00D, 4'hF);
    chk("post_abort_mask", 64'(req_mask_o), 64'h0);
    step(2);

    // Write timeout: no tx_done, err 17 cycles after the request pulse.
    t0 = cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h300;
    wb_sel_i = 4'hF; wb_cti_i = 3'b000; wb_dat_i = 32'h1234_5678;
    exp_wrq[t0 + 1]  = 32'h300;
    exp_err[t0 + 18] = 1'b1;
    step(18);
    chk("tmo_err", 64'(wb_err_o), 64'd1);
    step(1);
    idle_bus();
    step(1);
    tx_done_i = 1'b1;
    step(1);
    tx_done_i = 1'b0;
    step(2);
    bd[0] = 3;
    run_burst(1'b0, 32'h400, 2'b00, 1, 1'b0, 32'h4444_0000, 4'hF);
    step(2);

    // Reset during a read wait, then the late response must be ignored.
    t0 = cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h500;
    wb_sel_i = 4'hF; wb_cti_i = 3'b000;
    exp_rrq[t0 + 1] = 32'h500;
    step(4);
    wb_rst = 1'b1;
    step(1);
    wb_rst = 1'b0;
    idle_bus();
    chk_all_zero("midrst");
    step(1);
    rx_valid_i = 1'b1; rx_dat_i = 32'h5555_5555;
    step(1);
    rx_valid_i = 1'b0;
    step(2);
    bd[0] = 3;
    run_burst(1'b0, 32'h600, 2'b00, 1, 1'b0, 32'h6666_6666, 4'hF);
    chk("post_rst_dat", 64'(wb_dat_o), 64'h6666_6666);
    step(3);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
